mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 Parameter: STARVE_MAX, 4, consecutive data-port wins allowed while a fetch is pending; range 1..15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch request.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_ready  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  one-cycle pulse: fetch data valid.
REQ-010 if_rdata  out  DATA_W  fetch data.
REQ-011 dm_req  in  1  data-port request.
REQ-012 dm_we  in  1  data-port write enable.
REQ-013 dm_addr  in  ADDR_W  data address.
REQ-014 dm_wdata  in  DATA_W  write data.
REQ-015 dm_ready  out  1  data request accepted this cycle.
REQ-016 dm_rvalid  out  1  one-cycle pulse: data read or write completed.
REQ-017 dm_rdata  out  DATA_W  read data.
REQ-018 flush  in  1  pipeline flush; cancels fetch traffic only.
REQ-019 mem_req  out  1  request to the shared single-port memory.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  ADDR_W  memory address.
REQ-022 mem_wdata  out  DATA_W  memory write data.
REQ-023 mem_ack  in  1  memory completion, sampled while mem_req=1.
REQ-024 mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
REQ-025 busy  out  1  high in any state other than IDLE.

Function
REQ-026 The FSM SHALL have three states: IDLE, IF_BUSY, DM_BUSY.
REQ-027 if_ready and dm_ready SHALL be combinational, asserted only in IDLE, and at most one of them high in any cycle.
REQ-028 A request SHALL be accepted on a rising edge where req and ready are both 1. Address, data, and we SHALL be latched on that edge.
REQ-029 Arbitration in IDLE: the data port SHALL win when both request, except when streak==STARVE_MAX, in which case the fetch port SHALL win.
REQ-030 streak counter: +1 on each data acceptance while if_req=1; cleared on each fetch acceptance or on a data acceptance while if_req=0; saturates at STARVE_MAX.
REQ-031 Acceptance SHALL move the FSM to IF_BUSY or DM_BUSY. mem_req SHALL be registered: high from the next cycle until the mem_ack cycle, inclusive.
REQ-032 mem_addr, mem_we, and mem_wdata SHALL be stable while mem_req=1. mem_we SHALL be 0 for fetches.
REQ-033 On mem_ack: mem_req SHALL drop on that edge, FSM SHALL return to IDLE, and the owner's rvalid SHALL pulse high for exactly the following cycle with rdata = the registered mem_rdata.
REQ-034 For a data write, dm_rvalid SHALL pulse on completion with dm_rdata = 0.
REQ-035 Minimum latency: acceptance at edge N, mem_req high in cycle N+1, rvalid high in cycle N+2 when mem_ack arrives in cycle N+1.
REQ-036 A new acceptance SHALL be allowed in the same cycle that rvalid is high.
REQ-037 flush=1 in IDLE SHALL force if_ready=0 that cycle. dm_ready SHALL be unaffected.
REQ-038 flush=1 in any cycle of IF_BUSY, including the mem_ack cycle, SHALL suppress the pending if_rvalid. The memory transaction SHALL still complete normally.
REQ-039 flush SHALL have no effect on DM_BUSY or on dm_rvalid.
REQ-040 mem_ack received while mem_req=0 SHALL be ignored.

Reset
REQ-041 When rst=0, asynchronously: state=IDLE, streak=0, and mem_req, mem_we, if_rvalid, dm_rvalid, busy = 0.
REQ-042 When rst=0, asynchronously: mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
REQ-043 Reset in mid-transaction SHALL discard the transaction. No rvalid SHALL follow reset deassertion.

Verification
REQ-044 Single fetch: if_req=1, if_addr=0x100; mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> if_rvalid pulses once with if_rdata=0xDEADBEEF, 2 cycles after acceptance.
REQ-045 Simultaneous request: if_req=dm_req=1 in IDLE -> dm_ready=1 and if_ready=0; the fetch is granted immediately after the data completes.
REQ-046 Starvation: both ports request continuously with STARVE_MAX=4 -> grant order is D,D,D,D,I,D,D,D,D,I.
REQ-047 Flush: flush=1 while IF_BUSY with mem_ack delayed 3 cycles -> mem_req held until ack, if_rvalid stays 0, and the next fetch is accepted normally.
REQ-048 Write: dm_we=1, dm_addr=0x40, dm_wdata=0x12345678 -> mem_we=1 with matching addr and data, then dm_rvalid=1 and dm_rdata=0.
REQ-049 Reset mid-operation: rst=0 during DM_BUSY -> mem_req=0 and busy=0 immediately; after rst=1 with no requests, no rvalid pulse appears.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of a single-port memory.
// Data port has priority, bounded by a starvation counter that forces a fetch grant.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              flush,
  // shared memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_streak;
  logic              r_mem_req, r_mem_we, r_if_kill, r_if_rvalid, r_dm_rvalid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic              w_idle, w_streak_max, w_if_acc, w_dm_acc, w_ack;

  // A flushed fetch cannot be granted, so the data port may win even at the streak limit.
  always_comb begin
    w_idle       = (r_state == StIdle);
    w_streak_max = (r_streak == 4'(STARVE_MAX));
    w_if_acc     = w_idle && if_req && !flush && (!dm_req || w_streak_max);
    w_dm_acc     = w_idle && dm_req && !w_if_acc;
    w_ack        = r_mem_req && mem_ack;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_if_acc)      w_state_d = StIfBusy;
        else if (w_dm_acc) w_state_d = StDmBusy;
      end
      StIfBusy, StDmBusy: begin
        if (w_ack) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_kill   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      if (w_if_acc) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
        r_if_kill   <= 1'b0;
        r_streak    <= '0;
      end else if (w_dm_acc) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_we;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        if (!if_req)           r_streak <= '0;
        else if (!w_streak_max) r_streak <= r_streak + 4'd1;
      end
      // Remember any flush during the fetch so its response is dropped.
      if (r_state == StIfBusy && flush) r_if_kill <= 1'b1;
      if (w_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == StIfBusy) begin
          if (!(r_if_kill || flush)) begin
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= mem_rdata;
          end
        end else begin
          r_dm_rvalid <= 1'b1;
          r_dm_rdata  <= r_mem_we ? '0 : mem_rdata;
        end
      end
    end
  end

  assign if_ready  = w_if_acc;
  assign dm_ready  = w_dm_acc;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder with programmable ack delay,
// expected responses queued on acceptance and checked when rvalid/mem_ack appear.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_ready, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0, dm_ready, dm_rvalid;
  logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic        flush = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; int acc_cyc; int lat;} rsp_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; int len;} mreq_t;

  int          n_checks = 0, n_errors = 0;
  int          cyc = 0;
  rsp_t        if_q[$], dm_q[$], re;
  mreq_t       m_q[$], me;
  logic [31:0] mem_arr[256], exp_arr[256];
  int          ack_dly = 0, mcnt = 0, mlen = 0;
  bit          spur = 1'b0, if_out = 1'b0, if_kill = 1'b0, log_en = 1'b0;
  logic [7:0]  grants[$];
  int          if_rv_n = 0, dm_rv_n = 0, last_dm_rv = -1, last_if_acc = -2;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack after ack_dly extra cycles of mem_req.
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      mcnt = 0; mem_ack = 1'b0;
    end else begin
      if (mem_ack) mcnt = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (mcnt == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_arr[mem_addr[9:2]];
          if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
        end else mcnt++;
      end else if (spur) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if_q.delete(); dm_q.delete(); m_q.delete();
      if_out = 1'b0; if_kill = 1'b0; mlen = 0;
    end else begin
      check("rdy_excl", 64'(if_ready && dm_ready), 0);
      if (if_rvalid) begin
        if_rv_n++;
        if (if_q.size() == 0) check("if_unexp", 1, 0);
        else begin
          re = if_q.pop_front();
          check("if_rdata", if_rdata, re.data);
          check("if_lat", 64'(cyc - re.acc_cyc), 64'(re.lat));
        end
      end
      if (dm_rvalid) begin
        dm_rv_n++;
        last_dm_rv = cyc;
        if (dm_q.size() == 0) check("dm_unexp", 1, 0);
        else begin
          re = dm_q.pop_front();
          check("dm_rdata", dm_rdata, re.data);
          check("dm_lat", 64'(cyc - re.acc_cyc), 64'(re.lat));
        end
      end
      if (flush && if_out) if_kill = 1'b1;
      if (mem_req) mlen++;
      if (mem_req && mem_ack) begin
        if (m_q.size() == 0) check("mem_unexp", 1, 0);
        else begin
          me = m_q.pop_front();
          check("mem_addr", mem_addr, me.addr);
          check("mem_we", mem_we, me.we);
          if (me.we) check("mem_wdata", mem_wdata, me.wdata);
          check("mem_len", 64'(mlen), 64'(me.len));
        end
        mlen = 0;
        if (if_out) begin
          if_out = 1'b0;
          if (if_kill && if_q.size() > 0) if_q.delete(if_q.size() - 1);
        end
      end
      if (if_req && if_ready) begin
        if_q.push_back('{exp_arr[if_addr[9:2]], cyc, 2 + ack_dly});
        m_q.push_back('{if_addr, 1'b0, 32'h0, ack_dly + 1});
        if_out = 1'b1; if_kill = 1'b0; last_if_acc = cyc;
        if (log_en) grants.push_back("I");
      end
      if (dm_req && dm_ready) begin
        dm_q.push_back('{dm_we ? 32'h0 : exp_arr[dm_addr[9:2]], cyc, 2 + ack_dly});
        if (dm_we) exp_arr[dm_addr[9:2]] = dm_wdata;
        m_q.push_back('{dm_addr, dm_we, dm_wdata, ack_dly + 1});
        if (log_en) grants.push_back("D");
      end
    end
  end

  task automatic wait_acc(input bit is_dm);
    int k = 0;
    bit ok = 1'b0;
    while (!ok && k < 100) begin
      @(negedge clk);
      ok = is_dm ? (dm_req && dm_ready) : (if_req && if_ready);
      k++;
    end
    check(is_dm ? "dm_acc_to" : "if_acc_to", 64'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    wait_acc(1'b0);
    if_req = 1'b0;
  endtask

  task automatic issue_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    wait_acc(1'b1);
    dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    bit ok = 1'b0;
    while (!ok && k < 100) begin
      @(negedge clk); #1;
      ok = !busy && if_q.size() == 0 && dm_q.size() == 0 && !if_out;
      k++;
    end
    check("idle_to", 64'(ok), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n0, d0;
    int    k;
    string gs;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'hC0DE0000 | 32'(i);
      exp_arr[i] = 32'hC0DE0000 | 32'(i);
    end
    mem_arr[64] = 32'hDEADBEEF;
    exp_arr[64] = 32'hDEADBEEF;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_memreq", {mem_req, mem_we}, 0);
    check("rst_memaddr", mem_addr, 0);
    check("rst_memwdata", mem_wdata, 0);
    check("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
    check("rst_rdata", {if_rdata, dm_rdata}, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single fetch, minimum latency
    ack_dly = 0; n0 = if_rv_n;
    issue_if(32'h100);
    wait_idle();
    check("fetch_cnt", 64'(if_rv_n - n0), 1);

    // Write then read back through both ports
    issue_dm(1'b1, 32'h40, 32'h12345678);
    wait_idle();
    issue_dm(1'b0, 32'h40, 32'h0);
    wait_idle();
    issue_if(32'h40);
    wait_idle();

    // Simultaneous request: data first, fetch granted as data completes
    if_req = 1'b1; if_addr = 32'h8; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hC;
    @(negedge clk);
    check("sim_dm_rdy", dm_ready, 1);
    check("sim_if_rdy", if_ready, 0);
    @(posedge clk); #1 dm_req = 1'b0;
    wait_acc(1'b0);
    if_req = 1'b0;
    wait_idle();
    check("if_after_dm", 64'(last_if_acc), 64'(last_dm_rv));

    // Starvation bound
    ack_dly = 1; grants.delete(); log_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h14;
    k = 0;
    while (grants.size() < 10 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; log_en = 1'b0;
    wait_idle();
    gs = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++)
      check("grant", (i < grants.size()) ? grants[i] : 8'h0, gs[i]);

    // Flush in IDLE blocks only the fetch port
    ack_dly = 0;
    flush = 1'b1; if_req = 1'b1; if_addr = 32'h18;
    @(negedge clk);
    check("fl_if_rdy", if_ready, 0);
    @(posedge clk); #1 dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1C;
    @(negedge clk);
    check("fl_dm_rdy", dm_ready, 1);
    @(posedge clk); #1;
    dm_req = 1'b0; if_req = 1'b0; flush = 1'b0;
    wait_idle();

    // Flush during IF_BUSY (mid and in the ack cycle), slow memory
    ack_dly = 3; n0 = if_rv_n;
    issue_if(32'h20);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle();
    check("fl_mid_rv", 64'(if_rv_n - n0), 0);
    issue_if(32'h24);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle();
    check("fl_ack_rv", 64'(if_rv_n - n0), 0);
    ack_dly = 0;
    issue_if(32'h28);
    wait_idle();
    check("fl_next_rv", 64'(if_rv_n - n0), 1);

    // Spurious ack while idle
    n0 = if_rv_n; d0 = dm_rv_n;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("spur_busy", busy, 0);
    check("spur_rv", 64'(if_rv_n - n0 + dm_rv_n - d0), 0);

    // Reset in the middle of a data transaction
    ack_dly = 5;
    issue_dm(1'b0, 32'h30, 32'h0);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("mrst_memreq", mem_req, 0);
    check("mrst_busy", busy, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_ifrdata", if_rdata, 0);
    @(posedge clk); #1 rst = 1'b1;
    n0 = if_rv_n; d0 = dm_rv_n;
    repeat (8) @(posedge clk);
    #1;
    check("mrst_rv", 64'(if_rv_n - n0 + dm_rv_n - d0), 0);
    check("mrst_busy2", busy, 0);

    // Random mix of fetches, reads and writes
    for (int i = 0; i < 24; i++) begin
      ack_dly = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       issue_if({22'h0, 8'($urandom_range(0, 63)), 2'b00});
        1:       issue_dm(1'b0, {22'h0, 8'($urandom_range(0, 63)), 2'b00}, 32'h0);
        default: issue_dm(1'b1, {22'h0, 8'($urandom_range(0, 63)), 2'b00}, $urandom);
      endcase
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
